// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle RV64 load/store unit over a byte-addressed little-endian memory
module load_store_unit #(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [63:0]     wdata_q;
  logic            load_q;
  logic            mis_q;
  logic [7:0]      mem [DEPTH_BYTES];

  logic            accept;
  logic            complete;
  logic            req_mis;
  logic [2:0]      align_mask;
  logic [7:0]      st_en;
  logic [63:0]     raw;
  logic [63:0]     load_val;
  logic            unused_addr;

  assign unused_addr = ^address[63:AW];

  always_comb begin
    align_mask = 3'b000;
    case (funct3[1:0])
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      2'd3: align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
  end

  assign req_mis  = |(address[2:0] & align_mask);
  assign accept   = req_valid && (MemRead ^ MemWrite) && (state == IDLE || state == RESP);
  assign complete = (state == WAIT) && (cnt == '0);

  assign busy       = (state == WAIT);
  assign done       = (state == RESP);
  assign misaligned = (state == RESP) && mis_q;
  assign stall      = accept || busy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = req_mis ? RESP : WAIT;
      WAIT: if (cnt == '0) state_nxt = RESP;
      RESP: begin
        if (accept) state_nxt = req_mis ? RESP : WAIT;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gather eight bytes starting at the captured address; only the low size bytes matter.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[addr_q + AW'(i)];
  end

  always_comb begin
    load_val = raw;
    case (f3_q)
      3'b000:  load_val = {{56{raw[7]}},  raw[7:0]};
      3'b001:  load_val = {{48{raw[15]}}, raw[15:0]};
      3'b010:  load_val = {{32{raw[31]}}, raw[31:0]};
      3'b100:  load_val = {56'd0, raw[7:0]};
      3'b101:  load_val = {48'd0, raw[15:0]};
      3'b110:  load_val = {32'd0, raw[31:0]};
      default: load_val = raw;
    endcase
  end

  always_comb begin
    st_en = 8'h00;
    case (f3_q[1:0])
      2'd0: st_en = 8'h01;
      2'd1: st_en = 8'h03;
      2'd2: st_en = 8'h0f;
      2'd3: st_en = 8'hff;
      default: st_en = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      load_q    <= 1'b0;
      mis_q     <= 1'b0;
      read_data <= '0;
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        f3_q    <= funct3;
        addr_q  <= address[AW-1:0];
        wdata_q <= write_data;
        load_q  <= MemRead;
        mis_q   <= req_mis;
        cnt     <= CW'(LATENCY - 1);
        if (req_mis) read_data <= '0;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // The array is touched only on the edge that leaves WAIT for RESP.
      if (complete) begin
        if (load_q) begin
          read_data <= load_val;
        end else begin
          for (int i = 0; i < 8; i++)
            if (st_en[i]) mem[addr_q + AW'(i)] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the execute stage (`alu_result` as address, `read_data2` as store data) and `write_back` (`read_data`). It replaces the single-cycle combinational data memory with a byte-addressed, little-endian memory that has a fixed access latency. It supports RV64 byte/half/word/double loads and stores with sign/zero extension and misalignment detection. It raises `stall` so instruction fetch holds the PC until the access completes.

## Interface

- `DEPTH_BYTES`, default 256: memory size in bytes; power of two, ≥8.
- `LATENCY`, default 2: wait cycles per aligned access; ≥1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: an access request is presented this cycle.
- `MemRead` in 1: the request is a load.
- `MemWrite` in 1: the request is a store.
- `funct3` in 3: access size and signedness (inst[14:12]).
- `address` in 64: byte address; only bits [log2(DEPTH_BYTES)-1:0] are used.
- `write_data` in 64: store data; the low-order bytes are used.
- `read_data` out 64: load result; held until the next `done`.
- `busy` out 1: an access is in flight.
- `done` out 1: one-cycle completion pulse.
- `misaligned` out 1: qualifies `done`; the access was rejected.
- `stall` out 1: combinational; equals `accept` OR `busy`. Fetch holds the PC while it is high.

## Operation

- Load `funct3` encodings: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. 111 is treated as ld.
- Store `funct3` encodings: 000 sb, 001 sh, 010 sw, 011 sd. Bit 2 is ignored for stores.
- Access size is 1, 2, 4 or 8 bytes, from `funct3[1:0]`.
- `accept` = `req_valid` AND (`MemRead` XOR `MemWrite`) AND state ∈ {IDLE, RESP}.
- If `MemRead` and `MemWrite` are both high, the request is not accepted and the state is unchanged.
- FSM states: IDLE, WAIT, RESP.
  - IDLE → WAIT on `accept` when the access is aligned. The wait counter loads LATENCY-1.
  - IDLE → RESP on `accept` when the access is misaligned.
  - WAIT: the counter decrements each cycle. WAIT → RESP when the counter is 0.
  - RESP → WAIT or RESP on `accept`, using the same rules as IDLE. Otherwise RESP → IDLE.
- Alignment rule: `address` mod size must be 0. A misaligned access performs no array read or write and returns `read_data` = 0.
- Address wrap: the effective byte address is `address` mod DEPTH_BYTES. Multi-byte aligned accesses never straddle the wrap point.
- Loads:
  - Bytes [a, a+size-1] are assembled little-endian.
  - Signed loads sign-extend to 64 bits; lbu/lhu/lwu zero-extend.
  - The array is sampled on the edge that enters RESP.
- Stores:
  - The low size bytes of `write_data` are written to [a, a+size-1] on the edge that enters RESP.
  - All other bytes are untouched.
- The request fields (`funct3`, `address`, `write_data`, load/store kind) are captured on `accept`. Inputs may change while `busy` is high.
- Reset:
  - state goes to IDLE; `busy`, `done` and `misaligned` go to 0; `read_data` goes to 0.
  - The whole array is cleared to 0.
  - An in-flight store is discarded, even when it is mid-WAIT.
  - Reset has priority over `accept`.

## Timing

- Aligned request accepted at edge k:
  - `busy` = 1 for cycles k+1 … k+LATENCY.
  - `done` = 1 and `read_data` is valid in cycle k+LATENCY+1.
  - `misaligned` = 0.
- Misaligned request accepted at edge k:
  - `done` = 1 and `misaligned` = 1 in cycle k+1.
  - `busy` never rises.
- `done` and `misaligned` are registered and are low in every cycle outside RESP.
- Back-to-back requests: a request accepted in RESP goes directly to WAIT. Aligned `done` pulses are then LATENCY+1 cycles apart.
- `stall` is high in the accept cycle and in every WAIT cycle. It is low in RESP unless a new request is accepted in that cycle.
- A load after a store to the same byte, accepted in or after the store's RESP cycle, returns the new data.

## Test plan

- **Store/load double.** sd 0x1122334455667788 @0x10, then ld @0x10 (LATENCY=2) → `read_data` = 0x1122334455667788. `done` appears 3 cycles after each accept edge; `busy` is high for 2 cycles.
- **Byte store, signed and unsigned loads.** After the test above, sb 0x80 @0x13 →
  - lb @0x13 = 0xFFFFFFFFFFFFFF80
  - lbu @0x13 = 0x80
  - ld @0x10 = 0x1122334480667788
  - lw @0x10 = 0x0000000080667788 is wrong for lw; the signed result is 0xFFFFFFFF80667788, and lwu gives 0x0000000080667788.
- **Misaligned load.** lw @0x12 → `done` = 1 and `misaligned` = 1 one cycle after accept; `read_data` = 0; `busy` stays 0; the memory is unchanged, so a following ld @0x10 returns the prior value.
- **Address wrap.** sd 0xCAFE @0x108 (DEPTH_BYTES=256), then ld @0x08 → 0x000000000000CAFE.
- **Reset mid-store.** Accept sd 0xFFFF @0x10, then assert `reset` for 1 cycle during WAIT → `busy`, `done` and `read_data` are 0. A subsequent ld @0x10 returns 0.
- **Back-to-back, plus illegal request.**
  - `req_valid` held high across two loads → the second is accepted in the RESP cycle, and the `done` pulses are exactly 3 cycles apart.
  - A request with `MemRead` = `MemWrite` = 1 → not accepted; `stall` stays 0.
